// File: rtl/mem_arb_defs.sv
// mem_arb_defs: shared state encodings, grant owner and default timeout for mem_arbiter
package mem_arb_defs;
  typedef enum logic [1:0] {IDLE = 2'b00, SERVE_I = 2'b01, SERVE_D = 2'b10} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_t;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache refills and D-cache accesses onto one memory port
import mem_arb_defs::*;
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  state_t state_q, state_d;
  grant_t last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [CW-1:0]     cnt_q;
  logic i_req, d_req, grant, pick_d, serving;
  assign i_req   = i_re;
  assign d_req   = d_re ^ d_we;
  assign serving = state_q != IDLE;
  assign grant   = !serving && (i_req || d_req);
  // On a tie, alternate away from whoever was granted last
  assign pick_d  = (i_req && d_req) ? (last_q == GNT_I) : d_req;
  assign busy        = serving;
  assign mem_re      = serving && !we_q;
  assign mem_we      = serving && we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_done      = (state_q == SERVE_I) && mem_ready;
  assign d_done      = (state_q == SERVE_D) && mem_ready;
  assign i_rdata     = i_done ? mem_rdata : '0;
  assign d_rdata     = d_done ? mem_rdata : '0;
  assign timeout_err = serving && !mem_ready && (cnt_q == CW'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    state_d = grant ? (pick_d ? SERVE_D : SERVE_I) : (mem_ready || timeout_err) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_q  <= GNT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (grant) begin
      last_q  <= pick_d ? GNT_D : GNT_I;
      addr_q  <= pick_d ? d_addr : i_addr;
      wdata_q <= d_wdata;
      we_q    <= pick_d && d_we;
      cnt_q   <= '0;
    end else if (serving && !mem_ready) begin
      cnt_q   <= cnt_q + CW'(1);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario checks for mem_arbiter built with TIMEOUT=4
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_re = 1'b0, d_re = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, d_done, mem_re, mem_we, busy, timeout_err;
  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_re, mem_we}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if ({i_done, d_done, timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {i_done, d_done, timeout_err}); end
    reset = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_read;
    i_re = 1'b1; i_addr = 32'h40;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_grant_busy got=%b exp=0", busy); end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1; end
      checks++; if ({mem_re, mem_we} !== 2'b10) begin failures++; $display("FAIL rd_strobe_c%0d got=%b exp=10", c, {mem_re, mem_we}); end
      checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL rd_addr_c%0d got=%h exp=40", c, mem_addr); end
      checks++; if (i_done !== (c == 3)) begin failures++; $display("FAIL rd_done_c%0d got=%b exp=%b", c, i_done, c == 3); end
    end
    checks++; if (i_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", i_rdata); end
    checks++; if (d_done !== 1'b0) begin failures++; $display("FAIL rd_ddone got=%b exp=0", d_done); end
    i_re = 1'b0;
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if ({busy, mem_re} !== 2'b00) begin failures++; $display("FAIL rd_idle got=%b exp=00", {busy, mem_re}); end
  endtask

  task automatic test_tie;
    reset = 1'b0; #1; reset = 1'b1;
    i_re = 1'b1; i_addr = 32'h44; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
    step();
    checks++; if ({mem_re, mem_we} !== 2'b01) begin failures++; $display("FAIL tie1_strobe got=%b exp=01", {mem_re, mem_we}); end
    checks++; if (mem_addr !== 32'h80) begin failures++; $display("FAIL tie1_addr got=%h exp=80", mem_addr); end
    checks++; if (mem_wdata !== 32'h12345678) begin failures++; $display("FAIL tie1_wdata got=%h exp=12345678", mem_wdata); end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    #1;
    checks++; if ({d_done, i_done} !== 2'b10) begin failures++; $display("FAIL tie1_done got=%b exp=10", {d_done, i_done}); end
    checks++; if (d_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL tie1_rdata got=%h exp=cafe0001", d_rdata); end
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tie_gap got=%b exp=0", busy); end
    step();
    checks++; if ({mem_re, mem_we} !== 2'b10) begin failures++; $display("FAIL tie2_strobe got=%b exp=10", {mem_re, mem_we}); end
    checks++; if (mem_addr !== 32'h44) begin failures++; $display("FAIL tie2_addr got=%h exp=44", mem_addr); end
    mem_ready = 1'b1;
    #1;
    checks++; if ({d_done, i_done} !== 2'b01) begin failures++; $display("FAIL tie2_done got=%b exp=01", {d_done, i_done}); end
    i_re = 1'b0; d_we = 1'b0;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic test_invalid;
    d_re = 1'b1; d_we = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if ({busy, mem_re, mem_we} !== 3'b000) begin failures++; $display("FAIL invalid_c%0d got=%b exp=000", c, {busy, mem_re, mem_we}); end
    end
    d_re = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_timeout;
    i_re = 1'b1; i_addr = 32'h100;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (timeout_err !== (c == 4)) begin failures++; $display("FAIL to_err_c%0d got=%b exp=%b", c, timeout_err, c == 4); end
      checks++; if ({busy, i_done} !== 2'b10) begin failures++; $display("FAIL to_state_c%0d got=%b exp=10", c, {busy, i_done}); end
    end
    i_re = 1'b0;
    step();
    checks++; if ({busy, timeout_err} !== 2'b00) begin failures++; $display("FAIL to_idle got=%b exp=00", {busy, timeout_err}); end
  endtask

  task automatic test_withdrawn;
    i_re = 1'b1; i_addr = 32'h200;
    step();
    checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL wd_addr1 got=%h exp=200", mem_addr); end
    step();
    i_re = 1'b0; i_addr = 32'h999;
    #1;
    checks++; if ({mem_re, mem_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL wd_addr2 got=%b/%h exp=1/200", mem_re, mem_addr); end
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    checks++; if ({i_done, i_rdata} !== {1'b1, 32'h0BADF00D}) begin failures++; $display("FAIL wd_done got=%b/%h exp=1/0badf00d", i_done, i_rdata); end
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_idle got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset;
    d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h55AA55AA;
    step();
    checks++; if ({busy, mem_we} !== 2'b11) begin failures++; $display("FAIL ar_serve got=%b exp=11", {busy, mem_we}); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({busy, mem_we, d_done} !== 3'b000) begin failures++; $display("FAIL ar_drop got=%b exp=000", {busy, mem_we, d_done}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL ar_addr got=%h exp=0", mem_addr); end
    i_re = 1'b1; i_addr = 32'h400;
    #1;
    reset = 1'b1;
    step();
    checks++; if ({mem_re, mem_we} !== 2'b01) begin failures++; $display("FAIL ar_tie_strobe got=%b exp=01", {mem_re, mem_we}); end
    checks++; if (mem_addr !== 32'h300) begin failures++; $display("FAIL ar_tie_addr got=%h exp=300", mem_addr); end
    i_re = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_invalid();
    test_timeout();
    test_withdrawn();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width for all ports.
REQ-002 Parameter DATA_W, default 32: data width for all ports.
REQ-003 Parameter TIMEOUT, default 255: maximum number of SERVE cycles without mem_ready before the transaction is aborted.
REQ-004 clk, input, 1: single clock; all state updates on posedge clk.
REQ-005 reset, input, 1: asynchronous, active-low reset.
REQ-006 i_re, input, 1: instruction-cache refill read request.
REQ-007 i_addr, input, ADDR_W: instruction-side address.
REQ-008 i_rdata, output, DATA_W: instruction-side read data.
REQ-009 i_done, output, 1: instruction transaction complete (one-cycle pulse).
REQ-010 d_re / d_we, input, 1 each: data-cache read / write request.
REQ-011 d_addr, input, ADDR_W; d_wdata, input, DATA_W: data-side address and write data.
REQ-012 d_rdata, output, DATA_W; d_done, output, 1: data-side read data and completion pulse.
REQ-013 mem_re / mem_we, output, 1 each: main-memory read / write strobes.
REQ-014 mem_addr, output, ADDR_W; mem_wdata, output, DATA_W: main-memory address and write data.
REQ-015 mem_rdata, input, DATA_W; mem_ready, input, 1: main-memory read data and access-complete flag.
REQ-016 busy, output, 1; timeout_err, output, 1: serving status and one-cycle abort pulse.

Function
REQ-017 The FSM SHALL have three states, IDLE, SERVE_I and SERVE_D, with a 1-bit last_grant register (I or D).
REQ-018 A requester SHALL count as requesting only when exactly one of its strobes is high; d_re and d_we both high SHALL be ignored as invalid.
REQ-019 In IDLE with a single valid request, the FSM SHALL go to that requester's SERVE state on the next edge.
REQ-020 On a simultaneous I/D request in IDLE, the grant SHALL go to the side opposite last_grant, and last_grant SHALL update on every grant.
REQ-021 On the grant edge, the FSM SHALL latch the address, write data and direction into registers; mem_* outputs SHALL be driven only from these latched values.
REQ-022 mem_re or mem_we SHALL be high for every SERVE cycle and low in IDLE; both SHALL never be high together.
REQ-023 In SERVE_x with mem_ready=1, x_done SHALL be asserted combinationally in that cycle and the FSM SHALL return to IDLE on the next edge.
REQ-024 x_rdata SHALL pass mem_rdata through unchanged and is valid only while x_done=1.
REQ-025 Minimum occupancy SHALL be 1 grant cycle plus 1 serve cycle, with one mandatory IDLE cycle between transactions.
REQ-026 A request withdrawn during SERVE SHALL still complete from the latched values, and done SHALL still pulse.
REQ-027 A requester SHALL hold its request until its done pulse; a request still high after done SHALL re-arbitrate from IDLE.
REQ-028 A wait counter SHALL clear on grant and increment each SERVE cycle without mem_ready.
REQ-029 On the TIMEOUT-th such cycle, the FSM SHALL pulse timeout_err for one cycle, return to IDLE, and assert no done.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 While reset=0, the FSM SHALL immediately hold state=IDLE, last_grant=I, counter=0 and latched registers=0, independent of clk.
REQ-032 While reset=0, all outputs SHALL be 0, including mid-transaction: strobes drop asynchronously and no done is issued.

Structure
REQ-033 State encodings (IDLE=2'b00, SERVE_I=2'b01, SERVE_D=2'b10) and the default TIMEOUT SHALL live in the shared package/header file mem_arb_defs.
REQ-034 The FSM, latches and counter SHALL be implemented in one flat module with no sub-modules.

Verification
REQ-035 Single read: i_re=1, addr 0x40, mem_ready on the 3rd serve cycle with rdata 0xDEADBEEF -> mem_re high for 3 cycles, then i_done pulse with i_rdata=0xDEADBEEF.
REQ-036 Tie after reset: i_re and d_we together -> D served first (mem_we, d_wdata on mem_wdata), then I after one IDLE cycle; a second tie grants I.
REQ-037 Invalid request: d_re=d_we=1 with i_re=0 for 10 cycles -> busy=0, mem strobes stay 0.
REQ-038 Timeout: TIMEOUT=4 and mem_ready held 0 -> timeout_err pulses after 4 serve cycles, no done, state returns to IDLE.
REQ-039 Async reset: reset=0 mid-SERVE_D between clock edges -> mem_we and busy fall immediately; after release, a tie grants D.
REQ-040 Withdrawn request: i_re dropped on the 2nd serve cycle -> read completes at latched i_addr and i_done still pulses.
